// File: rtl/exc_pkg.sv
// Shared constants for the exception controller: ExcCodes, CP0 register
// indices, flag-vector bit positions and the sequencing FSM state type.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int unsigned CP0_BADVADDR = 8;
  localparam int unsigned CP0_STATUS   = 12;
  localparam int unsigned CP0_CAUSE    = 13;
  localparam int unsigned CP0_EPC      = 14;

  // Bit positions inside the exception flag vector, highest priority first
  localparam int unsigned FLG_ADEL_IF = 6;
  localparam int unsigned FLG_RI      = 5;
  localparam int unsigned FLG_OV      = 4;
  localparam int unsigned FLG_SYS     = 3;
  localparam int unsigned FLG_BP      = 2;
  localparam int unsigned FLG_ADEL_D  = 1;
  localparam int unsigned FLG_ADES    = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT
  } exc_state_t;

  function automatic logic [31:0] commit_we(input logic eret, input logic addr_err);
    logic [31:0] we;
    we = '0;
    we[CP0_STATUS] = 1'b1;
    if (!eret) begin
      we[CP0_CAUSE]    = 1'b1;
      we[CP0_EPC]      = 1'b1;
      we[CP0_BADVADDR] = addr_err;
    end
    return we;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority selector: interrupt, then exception flags in order, then ERET.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       int_pend,
  input  logic [6:0] flags,
  input  logic       mem_eret,
  output logic       hit,
  output logic       is_eret,
  output logic [4:0] code,
  output logic       is_addr_err
);

  always_comb begin
    hit         = 1'b1;
    is_eret     = 1'b0;
    code        = EXC_INT;
    is_addr_err = 1'b0;
    if (int_pend) begin
      code = EXC_INT;
    end else if (flags[FLG_ADEL_IF]) begin
      code        = EXC_ADEL;
      is_addr_err = 1'b1;
    end else if (flags[FLG_RI]) begin
      code = EXC_RI;
    end else if (flags[FLG_OV]) begin
      code = EXC_OV;
    end else if (flags[FLG_SYS]) begin
      code = EXC_SYS;
    end else if (flags[FLG_BP]) begin
      code = EXC_BP;
    end else if (flags[FLG_ADEL_D]) begin
      code        = EXC_ADEL;
      is_addr_err = 1'b1;
    end else if (flags[FLG_ADES]) begin
      code        = EXC_ADES;
      is_addr_err = 1'b1;
    end else if (mem_eret) begin
      is_eret = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: picks one MEM-stage event, sequences the CP0
// update, flush/stall and fetch redirect. EXC_CTRL_TIMER_INT_EN adds a
// Count/Compare timer interrupt on hw line 5.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [WIDTH-1:0] mem_pc,
  input  logic             mem_in_ds,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic             exc_adel_if,
  input  logic             exc_ri,
  input  logic             exc_ov,
  input  logic             exc_sys,
  input  logic             exc_bp,
  input  logic             exc_adel_d,
  input  logic             exc_ades,
  input  logic             mem_eret,
  input  logic             mem_busy,
  input  logic [5:0]       hw_int,
  input  logic [WIDTH-1:0] cp0_status,
  input  logic [WIDTH-1:0] cp0_cause,
  input  logic [WIDTH-1:0] cp0_epc,
  input  logic [WIDTH-1:0] cp0_count,
  input  logic [WIDTH-1:0] cp0_compare,
  input  logic             compare_we,
  output logic [31:0]      cp0_we,
  output logic [WIDTH-1:0] cp0_epc_o,
  output logic [WIDTH-1:0] cp0_badvaddr_o,
  output logic [4:0]       cp0_exccode,
  output logic             cp0_bd,
  output logic             cp0_exl,
  output logic [5:0]       cp0_hw_int,
  output logic             stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  input  logic             redirect_ready
);

  exc_state_t       state;
  logic             int_pend;
  logic [6:0]       flags;
  logic             hit, is_eret, is_addr_err;
  logic [4:0]       code;
  logic             accept;
  logic             lat_eret, lat_addr_err;
  logic             go_commit, c_eret, c_addr_err;
  logic [WIDTH-1:0] epc_calc, badv_calc;
  logic             unused_bits;

`ifdef EXC_CTRL_TIMER_INT_EN
  logic timer_pend;

  always_ff @(posedge clk) begin
    if (rst || compare_we)
      timer_pend <= 1'b0;
    else if (cp0_count == cp0_compare && cp0_compare != '0)
      timer_pend <= 1'b1;
  end

  assign cp0_hw_int = {hw_int[5] | timer_pend, hw_int[4:0]};
  assign unused_bits = ^{cp0_status[WIDTH-1:16], cp0_status[7:2],
                         cp0_cause[WIDTH-1:10], cp0_cause[7:0]};
`else
  assign cp0_hw_int = hw_int;
  assign unused_bits = ^{cp0_status[WIDTH-1:16], cp0_status[7:2],
                         cp0_cause[WIDTH-1:10], cp0_cause[7:0],
                         cp0_count, cp0_compare, compare_we};
`endif

  assign int_pend = cp0_status[0] & ~cp0_status[1] &
                    (|(cp0_status[15:8] & {cp0_hw_int, cp0_cause[9:8]}));

  assign flags = {exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades};

  exc_prio_enc u_prio (
    .int_pend    (int_pend),
    .flags       (flags),
    .mem_eret    (mem_eret),
    .hit         (hit),
    .is_eret     (is_eret),
    .code        (code),
    .is_addr_err (is_addr_err)
  );

  assign accept    = mem_valid & hit;
  assign epc_calc  = mem_in_ds ? mem_pc - WIDTH'(4) : mem_pc;
  // Only the fetch error outranks the data errors, so its flag alone picks the source
  assign badv_calc = exc_adel_if ? mem_pc : mem_addr;

  // Entry into COMMIT comes either straight from IDLE (use the live encoder
  // result) or from DRAIN (use the values latched at accept).
  assign go_commit  = (state == ST_IDLE && accept && !mem_busy) ||
                      (state == ST_DRAIN && !mem_busy);
  assign c_eret     = (state == ST_IDLE) ? is_eret : lat_eret;
  assign c_addr_err = (state == ST_IDLE) ? is_addr_err : lat_addr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cp0_we         <= '0;
      cp0_epc_o      <= '0;
      cp0_badvaddr_o <= '0;
      cp0_exccode    <= '0;
      cp0_bd         <= 1'b0;
      cp0_exl        <= 1'b0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      lat_eret       <= 1'b0;
      lat_addr_err   <= 1'b0;
    end else begin
      cp0_we  <= '0;
      cp0_exl <= 1'b0;
      flush   <= 1'b0;
      if (go_commit) begin
        cp0_we  <= commit_we(c_eret, c_addr_err);
        cp0_exl <= ~c_eret;
        flush   <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_eret     <= is_eret;
            lat_addr_err <= is_addr_err;
            cp0_exccode  <= code;
            cp0_bd       <= mem_in_ds;
            cp0_epc_o    <= epc_calc;
            if (is_addr_err)
              cp0_badvaddr_o <= badv_calc;
            stall <= 1'b1;
            state <= mem_busy ? ST_DRAIN : ST_COMMIT;
          end
        end
        ST_DRAIN: begin
          if (!mem_busy)
            state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= lat_eret ? cp0_epc : EXC_VECTOR;
          state          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            stall          <= 1'b0;
            state          <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
